// File: rtl/pipe_dp_pkg.sv
// pipe_dp_pkg
//   Shared definitions for the two-stage datapath:
//   - FS_* function-select codes understood by pipe_dp_alu
//   - flags_t, the {V,C,N,Z} flag bundle
//   - helper functions giving bit positions of the control-word fields.
//     Control word layout, MSB to LSB: DA[AW] AA[AW] BA[AW] MB FS[4] MD RW
package pipe_dp_pkg;

  // Function-select codes
  localparam logic [3:0] FS_A    = 4'b0000;  // F = A
  localparam logic [3:0] FS_INC  = 4'b0001;  // F = A + 1
  localparam logic [3:0] FS_ADD  = 4'b0010;  // F = A + B
  localparam logic [3:0] FS_ADDC = 4'b0011;  // F = A + B + 1
  localparam logic [3:0] FS_SUBB = 4'b0100;  // F = A + ~B
  localparam logic [3:0] FS_SUB  = 4'b0101;  // F = A + ~B + 1
  localparam logic [3:0] FS_DEC  = 4'b0110;  // F = A - 1
  localparam logic [3:0] FS_A7   = 4'b0111;  // F = A
  localparam logic [3:0] FS_AND  = 4'b1000;  // F = A & B
  localparam logic [3:0] FS_OR   = 4'b1001;  // F = A | B
  localparam logic [3:0] FS_XOR  = 4'b1010;  // F = A ^ B
  localparam logic [3:0] FS_NOT  = 4'b1011;  // F = ~A
  localparam logic [3:0] FS_B    = 4'b1100;  // F = B
  localparam logic [3:0] FS_SHR  = 4'b1101;  // F = B >> 1 (logical)
  localparam logic [3:0] FS_SHL  = 4'b1110;  // F = B << 1
  localparam logic [3:0] FS_RSV  = 4'b1111;  // reserved, behaves as F = A

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

  // Arithmetic codes are the only ones that can raise V.
  function automatic logic is_arith(input logic [3:0] fs);
    return (fs >= FS_INC) && (fs <= FS_DEC);
  endfunction

  // Control-word geometry
  function automatic int cw_width(input int aw);
    return 3 * aw + 7;
  endfunction

  function automatic int cw_rw_bit();
    return 0;
  endfunction

  function automatic int cw_md_bit();
    return 1;
  endfunction

  function automatic int cw_fs_lsb();
    return 2;
  endfunction

  function automatic int cw_mb_bit();
    return 6;
  endfunction

  function automatic int cw_ba_lsb(input int aw);
    return 7 + 0 * aw;
  endfunction

  function automatic int cw_aa_lsb(input int aw);
    return 7 + aw;
  endfunction

  function automatic int cw_da_lsb(input int aw);
    return 7 + 2 * aw;
  endfunction

endpackage

// File: rtl/pipe_dp_alu.sv
// pipe_dp_alu
//   Purely combinational function unit for the execute stage.
//   Ports:
//     a, b   [WIDTH]  operands (A from the register file, B from regs or Cin)
//     fs     [4]      function select (FS_* codes in pipe_dp_pkg)
//     f      [WIDTH]  result
//     flags  flags_t  flag candidates for this result; the caller decides
//                     whether they are committed.
module pipe_dp_alu
  import pipe_dp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fs,
  output logic [WIDTH-1:0] f,
  output flags_t           flags
);

  // All arithmetic codes share one adder: A + bop + cin_b.
  logic [WIDTH-1:0] bop;
  logic             cin_b;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;

  always_comb begin
    bop   = '0;
    cin_b = 1'b0;
    case (fs)
      FS_INC:  cin_b = 1'b1;
      FS_ADD:  bop   = b;
      FS_ADDC: begin
        bop   = b;
        cin_b = 1'b1;
      end
      FS_SUBB: bop   = ~b;
      FS_SUB:  begin
        bop   = ~b;
        cin_b = 1'b1;
      end
      FS_DEC:  bop   = '1;
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin_b};

  // Signed overflow: both adder inputs agree in sign but the result does not.
  assign ovf = is_arith(fs) && (a[WIDTH-1] == bop[WIDTH-1])
               && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    f     = a;
    carry = 1'b0;
    case (fs)
      FS_A, FS_INC, FS_ADD, FS_ADDC, FS_SUBB, FS_SUB, FS_DEC, FS_A7: begin
        f     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      FS_AND: f = a & b;
      FS_OR:  f = a | b;
      FS_XOR: f = a ^ b;
      FS_NOT: f = ~a;
      FS_B:   f = b;
      FS_SHR: begin
        f     = {1'b0, b[WIDTH-1:1]};
        carry = b[0];
      end
      FS_SHL: begin
        f     = {b[WIDTH-2:0], 1'b0};
        carry = b[WIDTH-1];
      end
      default: f = a;  // FS_RSV
    endcase
  end

  always_comb begin
    flags   = '0;
    flags.v = ovf;
    flags.c = carry;
    flags.n = f[WIDTH-1];
    flags.z = (f == '0);
  end

endmodule

// File: rtl/pipe_datapath.sv
// pipe_datapath
//   Two-stage micro-op datapath with an NREG x WIDTH register file.
//   S1 (issue) decodes CTRWRD and reads operands; S2 (execute) runs the ALU
//   or waits for memory data, then writes back to R[DA].
//   Ports:
//     CLK        clock, rising edge
//     RESET      synchronous, active-low
//     CTRWRD     [CW] control word DA|AA|BA|MB|FS|MD|RW
//     CW_VALID   CTRWRD/Cin are offered this cycle
//     CW_READY   the offered micro-op is accepted this cycle
//     Cin        [WIDTH] constant operand, used as B when MB=1
//     Din        [WIDTH] memory read data, written back when MD=1
//     DIN_VALID  Din is valid this cycle
//     Adrout     [WIDTH] A operand of the micro-op held in S2
//     Dout       [WIDTH] B operand of the micro-op held in S2
//     MEM_REQ    S2 holds an MD=1 op still waiting for Din
//     V,C,N,Z    registered flags
//
//   Handshake: a micro-op transfers into S2 on a rising edge where
//   CW_VALID && CW_READY. CW_READY does not depend on CW_VALID; it is high
//   when S2 is empty or S2 finishes in this same cycle, so a dependent op
//   can follow with no bubble. While an op waits, CTRWRD/Cin must be held.
module pipe_datapath
  import pipe_dp_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = cw_width(AW)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [CW-1:0]    CTRWRD,
  input  logic             CW_VALID,
  output logic             CW_READY,
  input  logic [WIDTH-1:0] Cin,
  input  logic [WIDTH-1:0] Din,
  input  logic             DIN_VALID,
  output logic [WIDTH-1:0] Adrout,
  output logic [WIDTH-1:0] Dout,
  output logic             MEM_REQ,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z
);

  localparam int DA_LSB = cw_da_lsb(AW);
  localparam int AA_LSB = cw_aa_lsb(AW);
  localparam int BA_LSB = cw_ba_lsb(AW);
  localparam int MB_BIT = cw_mb_bit();
  localparam int FS_LSB = cw_fs_lsb();
  localparam int MD_BIT = cw_md_bit();
  localparam int RW_BIT = cw_rw_bit();

  // ---------------- S1: decode of the offered control word ----------------
  logic [AW-1:0] in_da;
  logic [AW-1:0] in_aa;
  logic [AW-1:0] in_ba;
  logic          in_mb;
  logic [3:0]    in_fs;
  logic          in_md;
  logic          in_rw;

  assign in_da = CTRWRD[DA_LSB +: AW];
  assign in_aa = CTRWRD[AA_LSB +: AW];
  assign in_ba = CTRWRD[BA_LSB +: AW];
  assign in_mb = CTRWRD[MB_BIT];
  assign in_fs = CTRWRD[FS_LSB +: 4];
  assign in_md = CTRWRD[MD_BIT];
  assign in_rw = CTRWRD[RW_BIT];

  // ---------------- State ----------------
  logic [WIDTH-1:0] regs [NREG];

  logic             s2_valid;
  logic [AW-1:0]    s2_da;
  logic [3:0]       s2_fs;
  logic             s2_md;
  logic             s2_rw;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  flags_t           flags_q;

  // ---------------- S2: execute ----------------
  logic [WIDTH-1:0] alu_f;
  flags_t           alu_flags;

  pipe_dp_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .fs    (s2_fs),
    .f     (alu_f),
    .flags (alu_flags)
  );

  // ---------------- Pipeline control ----------------
  logic             s2_done;
  logic             accept;
  logic             wb_en;
  logic [WIDTH-1:0] wb_val;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // An ALU op always finishes in one cycle; a load finishes when Din arrives.
  // DIN_VALID has no effect unless a load is sitting in S2.
  assign s2_done  = s2_valid && (!s2_md || DIN_VALID);
  assign CW_READY = !s2_valid || s2_done;
  assign accept   = CW_VALID && CW_READY;

  assign wb_val = s2_md ? Din : alu_f;
  assign wb_en  = s2_done && s2_rw;

  // Bypass: the op finishing in S2 writes R[DA] at the same edge the new op
  // captures its operands, so its result is forwarded instead of the stale
  // register-file value.
  assign fwd_a = wb_en && (s2_da == in_aa);
  assign fwd_b = wb_en && (s2_da == in_ba);

  assign op_a = fwd_a ? wb_val : regs[in_aa];
  assign op_b = in_mb ? Cin : (fwd_b ? wb_val : regs[in_ba]);

  // Reset takes priority over everything, so a load pending at a reset edge
  // never writes back.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s2_valid <= 1'b0;
      s2_da    <= '0;
      s2_fs    <= FS_A;
      s2_md    <= 1'b0;
      s2_rw    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        regs[s2_da] <= wb_val;
      end
      // Loads leave the flags alone; only ALU results update them.
      if (s2_done && !s2_md) begin
        flags_q <= alu_flags;
      end
      if (accept) begin
        s2_valid <= 1'b1;
        s2_da    <= in_da;
        s2_fs    <= in_fs;
        s2_md    <= in_md;
        s2_rw    <= in_rw;
        a_q      <= op_a;
        b_q      <= op_b;
      end else if (s2_done) begin
        // S2 drains; operand outputs keep their last values.
        s2_valid <= 1'b0;
      end
    end
  end

  // ---------------- Outputs ----------------
  assign Adrout  = a_q;
  assign Dout    = b_q;
  assign MEM_REQ = s2_valid && s2_md && !DIN_VALID;
  assign V       = flags_q.v;
  assign C       = flags_q.c;
  assign N       = flags_q.n;
  assign Z       = flags_q.z;

endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath
//   Directed bench for pipe_datapath. Two instances: the default 16-bit /
//   8-register build and an 8-bit / 16-register build. Registers are observed
//   by issuing "read" micro-ops (FS=A, RW=0) and looking at Adrout/Dout one
//   cycle later.
module tb_pipe_datapath;

  // ---------------- Clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 16-bit, 8-register instance ----------------
  logic [15:0] ctrwrd;
  logic        cw_valid;
  logic        cw_ready;
  logic [15:0] cin;
  logic [15:0] din;
  logic        din_valid;
  logic [15:0] adrout;
  logic [15:0] dout;
  logic        mem_req;
  logic        v, c, n, z;

  pipe_datapath #(
    .WIDTH (16),
    .NREG  (8)
  ) dut (
    .CLK       (clk),
    .RESET     (reset),
    .CTRWRD    (ctrwrd),
    .CW_VALID  (cw_valid),
    .CW_READY  (cw_ready),
    .Cin       (cin),
    .Din       (din),
    .DIN_VALID (din_valid),
    .Adrout    (adrout),
    .Dout      (dout),
    .MEM_REQ   (mem_req),
    .V         (v),
    .C         (c),
    .N         (n),
    .Z         (z)
  );

  // ---------------- 8-bit, 16-register instance ----------------
  logic [18:0] ctrwrd_8;
  logic        cw_valid_8;
  logic        cw_ready_8;
  logic [7:0]  cin_8;
  logic [7:0]  din_8;
  logic        din_valid_8;
  logic [7:0]  adrout_8;
  logic [7:0]  dout_8;
  logic        mem_req_8;
  logic        v_8, c_8, n_8, z_8;

  pipe_datapath #(
    .WIDTH (8),
    .NREG  (16)
  ) dut8 (
    .CLK       (clk),
    .RESET     (reset),
    .CTRWRD    (ctrwrd_8),
    .CW_VALID  (cw_valid_8),
    .CW_READY  (cw_ready_8),
    .Cin       (cin_8),
    .Din       (din_8),
    .DIN_VALID (din_valid_8),
    .Adrout    (adrout_8),
    .Dout      (dout_8),
    .MEM_REQ   (mem_req_8),
    .V         (v_8),
    .C         (c_8),
    .N         (n_8),
    .Z         (z_8)
  );

  // ---------------- Scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent control-word packer: DA|AA|BA|MB|FS[4]|MD|RW
  function automatic logic [18:0] pack(input int aw, input int da, input int aa,
                                       input int ba, input int mb, input int fs,
                                       input int md, input int rw);
    int w;
    w = (da << (7 + 2 * aw)) | (aa << (7 + aw)) | (ba << 7) | (mb << 6)
        | (fs << 2) | (md << 1) | rw;
    return w[18:0];
  endfunction

  // ---------------- Driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one micro-op; it must be accepted at the next edge.
  task automatic op(input int inst, input logic [18:0] cw, input logic [15:0] k);
    if (inst == 0) begin
      ctrwrd   = cw[15:0];
      cin      = k;
      cw_valid = 1'b1;
      #1;
      check("ready16", 32'(cw_ready), 32'd1);
    end else begin
      ctrwrd_8   = cw;
      cin_8      = k[7:0];
      cw_valid_8 = 1'b1;
      #1;
      check("ready8", 32'(cw_ready_8), 32'd1);
    end
    tick();
  endtask

  // Read R[aa] onto Adrout through a FS=A, RW=0 micro-op.
  task automatic rd(input int inst, input int aa, input int ba, input logic [15:0] exp_a);
    exp_q.push_back(exp_a);
    op(inst, pack((inst == 0) ? 3 : 4, 0, aa, ba, 0, 0, 0, 0), 16'h0);
    if (inst == 0) check("rd_adrout16", 32'(adrout), 32'(exp_q.pop_front()));
    else           check("rd_adrout8", 32'(adrout_8), 32'(exp_q.pop_front()));
  endtask

  // ---------------- Watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1);
  end

  // ---------------- Stimulus ----------------
  initial begin
    reset       = 1'b0;
    ctrwrd      = '0;
    cw_valid    = 1'b0;
    cin         = '0;
    din         = '0;
    din_valid   = 1'b0;
    ctrwrd_8    = '0;
    cw_valid_8  = 1'b0;
    cin_8       = '0;
    din_8       = '0;
    din_valid_8 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_adrout", 32'(adrout), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_flags", 32'({v, c, n, z}), 32'h0);
    check("rst_memreq", 32'(mem_req), 32'h0);
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(cw_ready), 32'h1);

    // R1 <- 5, R2 <- R1+R1 back-to-back (bypass on both operands)
    op(0, pack(3, 1, 0, 0, 1, 4'hC, 0, 1), 16'h0005);
    op(0, pack(3, 2, 1, 1, 0, 4'h2, 0, 1), 16'h0000);
    rd(0, 2, 1, 16'h000A);
    check("add_dout_r1", 32'(dout), 32'h0005);
    check("add_flags", 32'({v, c, n, z}), 32'b0000);

    // R3 <- 0x7FFF, R3 <- R3+1 -> 0x8000, V=1 N=1 C=0 Z=0
    op(0, pack(3, 3, 0, 0, 1, 4'hC, 0, 1), 16'h7FFF);
    op(0, pack(3, 3, 3, 0, 0, 4'h1, 0, 1), 16'h0000);
    rd(0, 3, 3, 16'h8000);
    check("inc_flags", 32'({v, c, n, z}), 32'b1010);

    // R4 <- 0x1234, R4 <- R4 + ~R4 + 1 -> 0, Z=1 C=1 V=0 N=0
    op(0, pack(3, 4, 0, 0, 1, 4'hC, 0, 1), 16'h1234);
    op(0, pack(3, 4, 4, 4, 0, 4'h5, 0, 1), 16'h0000);
    rd(0, 4, 4, 16'h0000);
    check("sub_flags", 32'({v, c, n, z}), 32'b0101);

    // R7 <- Cin >> 1 with Cin=3 -> 1, C = shifted-out bit
    op(0, pack(3, 7, 0, 0, 1, 4'hD, 0, 1), 16'h0003);
    rd(0, 7, 7, 16'h0001);
    check("shr_flags", 32'({v, c, n, z}), 32'b0100);

    // Load R5 <- Din with three stall cycles. The read of R3 completes at the
    // edge the load is accepted, leaving flags N=1 only.
    rd(0, 3, 3, 16'h8000);
    op(0, pack(3, 5, 0, 0, 0, 4'h0, 1, 1), 16'h0000);
    check("pre_load_flags", 32'({v, c, n, z}), 32'b0010);
    ctrwrd   = pack(3, 0, 5, 5, 0, 0, 0, 0)[15:0];
    cw_valid = 1'b1;
    exp_q.push_back(16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_memreq", 32'(mem_req), 32'h1);
      check("stall_ready", 32'(cw_ready), 32'h0);
      tick();
    end
    din       = 16'hBEEF;
    din_valid = 1'b1;
    #1;
    check("load_done_memreq", 32'(mem_req), 32'h0);
    check("load_done_ready", 32'(cw_ready), 32'h1);
    tick();
    din_valid = 1'b0;
    cw_valid  = 1'b0;
    check("load_bypass_r5", 32'(adrout), 32'(exp_q.pop_front()));
    check("load_flags_held", 32'({v, c, n, z}), 32'b0010);
    tick();

    // Reset in the middle of a load stall discards the load
    op(0, pack(3, 5, 0, 0, 0, 4'h0, 1, 1), 16'h0000);
    cw_valid = 1'b0;
    tick();
    check("stall2_memreq", 32'(mem_req), 32'h1);
    reset     = 1'b0;
    din       = 16'h5A5A;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    #1;
    check("rst_stall_memreq", 32'(mem_req), 32'h0);
    check("rst_stall_flags", 32'({v, c, n, z}), 32'h0);
    check("rst_stall_adrout", 32'(adrout), 32'h0);
    reset = 1'b1;
    rd(0, 5, 5, 16'h0000);

    // 8-bit, 16-register build
    op(1, pack(4, 1, 0, 0, 1, 4'hC, 0, 1), 16'h0005);
    op(1, pack(4, 2, 1, 1, 0, 4'h2, 0, 1), 16'h0000);
    rd(1, 2, 2, 16'h000A);
    check("w8_add_flags", 32'({v_8, c_8, n_8, z_8}), 32'b0000);
    op(1, pack(4, 15, 0, 0, 1, 4'hC, 0, 1), 16'h007F);
    op(1, pack(4, 15, 15, 0, 0, 4'h1, 0, 1), 16'h0000);
    rd(1, 15, 15, 16'h0080);
    check("w8_inc_flags", 32'({v_8, c_8, n_8, z_8}), 32'b1010);
    cw_valid_8 = 1'b0;
    tick();
    check("w8_idle_memreq", 32'(mem_req_8), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
